// File: rtl/contador_simple_core.sv
// Four-key press counter: sync, edge detect, per-key count.
// Each key counts rising edges of its synchronized level.
module contador_simple_core #(
  parameter int CNT_W    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       key_state,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1,
  output logic [CNT_W-1:0] count2,
  output logic [CNT_W-1:0] count3
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       prev;
  logic [3:0]       press;
  logic [CNT_W-1:0] cnt [4];

  // Rising edge of the synchronized level, one cycle wide.
  always_comb begin
    press = sync2 & ~prev;
  end

  // Synchronizer, edge history and per-key counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= key_state;
      sync2 <= sync1;
      prev  <= sync2;
      for (int i = 0; i < 4; i++) begin
        if (press[i]) begin
          if (SATURATE && cnt[i] == MAX) begin
            cnt[i] <= cnt[i];
          end else begin
            cnt[i] <= cnt[i] + ONE;
          end
        end
      end
    end
  end

  assign count0 = cnt[0];
  assign count1 = cnt[1];
  assign count2 = cnt[2];
  assign count3 = cnt[3];

endmodule

// File: tb/tb_contador_simple_core.sv
// Bench for contador_simple_core: wrap and saturate instances
// checked against a press-history reference model.
module tb_contador_simple_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] key_state = 4'h0;
  logic [3:0] cw [4];
  logic [3:0] cs [4];

  int checks = 0;
  int errors = 0;

  logic [3:0] hist [$];

  always #5 clk = ~clk;

  contador_simple_core #(.CNT_W(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .key_state(key_state),
    .count0(cw[0]), .count1(cw[1]),
    .count2(cw[2]), .count3(cw[3])
  );

  contador_simple_core #(.CNT_W(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .key_state(key_state),
    .count0(cs[0]), .count1(cs[1]),
    .count2(cs[2]), .count3(cs[3])
  );

  // Key levels seen at each clock edge since reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) hist.delete();
    else hist.push_back(key_state);
  end

  // A press sampled at edge k shows up after edge k+2.
  function automatic int ref_cnt(int i, bit sat);
    int c = 0;
    int n = hist.size();
    for (int k = 0; k <= n - 3; k++) begin
      if (hist[k][i] && (k == 0 || !hist[k-1][i])) begin
        if (sat) c = (c == 15) ? 15 : c + 1;
        else c = (c + 1) % 16;
      end
    end
    return c;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_w%0d", tag, i), 32'(cw[i]), ref_cnt(i, 1'b0));
      chk($sformatf("%s_s%0d", tag, i), 32'(cs[i]), ref_cnt(i, 1'b1));
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] m);
    key_state = m;
    cycles(1);
    key_state = 4'h0;
    cycles(3);
  endtask

  task automatic chk4(input string tag, input int e0, input int e1,
                      input int e2, input int e3);
    chk({tag, "_c0"}, 32'(cw[0]), e0);
    chk({tag, "_c1"}, 32'(cw[1]), e1);
    chk({tag, "_c2"}, 32'(cw[2]), e2);
    chk({tag, "_c3"}, 32'(cw[3]), e3);
  endtask

  initial begin
    reset = 1'b0;
    key_state = 4'h0;
    cycles(2);
    chk4("rst", 0, 0, 0, 0);
    reset = 1'b1;
    cycles(2);
    chk4("idle", 0, 0, 0, 0);
    chk_model("idle");

    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b0001);
    chk4("basic", 2, 1, 0, 0);
    chk_model("basic");

    pulse(4'b1100);
    chk4("simul", 2, 1, 1, 1);

    key_state = 4'b0010;
    cycles(50);
    key_state = 4'h0;
    cycles(3);
    chk4("held", 2, 2, 1, 1);
    chk_model("held");

    reset = 1'b0;
    cycles(1);
    reset = 1'b1;
    cycles(2);
    for (int p = 0; p < 15; p++) begin
      key_state = 4'b1000;
      cycles(1);
      key_state = 4'h0;
      cycles(2);
    end
    chk("max_w3", 32'(cw[3]), 15);
    chk("max_s3", 32'(cs[3]), 15);
    key_state = 4'b1000;
    cycles(1);
    key_state = 4'h0;
    cycles(2);
    chk("wrap_w3", 32'(cw[3]), 0);
    chk("sat_s3", 32'(cs[3]), 15);
    chk_model("wrap");

    key_state = 4'b0100;
    @(posedge clk); #1;
    chk("lat_k", 32'(cw[2]), 0);
    @(posedge clk); #1;
    chk("lat_k1", 32'(cw[2]), 0);
    @(posedge clk); #1;
    chk("lat_k2", 32'(cw[2]), 1);
    @(negedge clk);
    key_state = 4'h0;
    cycles(3);

    key_state = 4'b0001;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk4("async", 0, 0, 0, 0);
    chk("async_s3", 32'(cs[3]), 0);
    @(negedge clk);
    reset = 1'b1;
    cycles(5);
    chk("relhold", 32'(cw[0]), 1);
    cycles(5);
    chk("relhold2", 32'(cw[0]), 1);
    chk_model("relhold");
    key_state = 4'h0;
    cycles(3);

    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 49) == 0) begin
        #($urandom_range(1, 4));
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end else if ($urandom_range(0, 3) == 0) begin
        key_state = 4'($urandom);
      end
      @(negedge clk);
      chk_model("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
